// File: rtl/doc_hw_pkg_hw.sv
// Shared types and sizing for the sensor collection path and its limit monitor.
// Channel counts here are the single source of truth for every consumer.
package doc_hw_pkg_hw;

  localparam int P_NO_CHANNELS      = 4;
  localparam int P_NO_TEMP_CHANNELS = 2;
  localparam int P_DEBOUNCE_MAX     = 15;
  localparam int DBC_W              = $clog2(P_DEBOUNCE_MAX + 1);

  typedef enum logic [2:0] {IDLE, SNAP, SCAN_V, SCAN_T, DONE} mon_state_t;
  typedef logic [31:0] volt_code_t;
  typedef logic [7:0]  temp_code_t;

  // A clear zeroes the count first; the current check result is then applied on top.
  function automatic logic [DBC_W-1:0] dbc_next(input logic [DBC_W-1:0] cnt,
                                                input logic clr, input logic hit,
                                                input logic fail, input logic [DBC_W-1:0] lim);
    logic [DBC_W-1:0] base;
    logic [DBC_W-1:0] res;
    base = clr ? '0 : cnt;
    res  = base;
    if (hit) begin
      if (!fail) res = '0;
      else if (base >= lim) res = lim;
      else res = base + DBC_W'(1);
    end
    return res;
  endfunction

  // Latch decision uses the pre-clear count so a coincident clear cannot mask a fault.
  function automatic logic dbc_set(input logic [DBC_W-1:0] cnt, input logic hit,
                                   input logic fail, input logic [DBC_W-1:0] lim);
    return hit && fail && (cnt >= lim - DBC_W'(1));
  endfunction

endpackage

// File: rtl/doc_hw_stale_wdog.sv
// Watchdog on one good flag: sticky stale bit when no kick arrives within P_STALE_CYCLES.
module doc_hw_stale_wdog #(
  parameter int P_STALE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic kick_i,
  input  logic clear_i,
  output logic stale_o
);
  localparam int CW = $clog2(P_STALE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(P_STALE_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(P_STALE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d, base;
  logic stale_q, stale_d, set;

  always_comb begin
    base = clear_i ? '0 : cnt_q;
    set  = !kick_i && (cnt_q == LAST);
    if (kick_i) cnt_d = '0;
    else if (base == LIMIT) cnt_d = base;
    else cnt_d = base + CW'(1);
    stale_d = (stale_q & ~clear_i) | set;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
    end
  end

  assign stale_o = stale_q;
endmodule

// File: rtl/doc_hw_sensor_limit_monitor.sv
// Snapshots voltage/temperature collections on each sweep and scans them one channel per cycle
// against programmable limits, with per-channel debounce, sticky faults and stale-data watchdogs.
module doc_hw_sensor_limit_monitor
  import doc_hw_pkg_hw::*;
#(
  parameter int P_DEBOUNCE     = 3,
  parameter int P_STALE_CYCLES = 1_000_000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                voltage_good,
  input  logic                                temperature_good,
  input  logic [P_NO_CHANNELS-1:0][31:0]      voltage_collection,
  input  logic [P_NO_TEMP_CHANNELS-1:0][7:0]  temperature_collection,
  input  logic [P_NO_CHANNELS-1:0][31:0]      volt_min_i,
  input  logic [P_NO_CHANNELS-1:0][31:0]      volt_max_i,
  input  logic [P_NO_TEMP_CHANNELS-1:0][7:0]  temp_max_i,
  input  logic                                clear_i,
  output logic [P_NO_CHANNELS-1:0]            volt_fault_o,
  output logic [P_NO_TEMP_CHANNELS-1:0]       temp_fault_o,
  output logic [1:0]                          stale_fault_o,
  output logic                                overrun_o,
  output logic                                fault_o,
  output logic                                scan_done_o
);
  localparam int NV     = P_NO_CHANNELS;
  localparam int NT     = P_NO_TEMP_CHANNELS;
  localparam int VIDX_W = (NV > 1) ? $clog2(NV) : 1;
  localparam int TIDX_W = (NT > 1) ? $clog2(NT) : 1;
  localparam int IDX_W  = (VIDX_W > TIDX_W) ? VIDX_W : TIDX_W;
  localparam logic [DBC_W-1:0] DBC_LIM = DBC_W'(P_DEBOUNCE);

  mon_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic sw_q, vg_q, tg_q, sweep_edge;
  volt_code_t [NV-1:0] vshadow_q;
  temp_code_t [NT-1:0] tshadow_q;
  logic [VIDX_W-1:0] vi;
  logic [TIDX_W-1:0] ti;
  logic v_chk, t_chk, v_fail, t_fail;
  logic [NV-1:0][DBC_W-1:0] vdbc_q, vdbc_d;
  logic [NT-1:0][DBC_W-1:0] tdbc_q, tdbc_d;
  logic [NV-1:0] vfault_q, vfault_d;
  logic [NT-1:0] tfault_q, tfault_d;
  logic overrun_q, fault_q;
  logic [1:0] stale_w;

  assign sweep_edge = voltage_good & temperature_good & ~sw_q;
  assign vi    = idx_q[VIDX_W-1:0];
  assign ti    = idx_q[TIDX_W-1:0];
  assign v_chk = (state_q == SCAN_V);
  assign t_chk = (state_q == SCAN_T);
  // One comparator path, steered by idx; limits are read live.
  assign v_fail = (vshadow_q[vi] < volt_min_i[vi]) || (vshadow_q[vi] > volt_max_i[vi]);
  assign t_fail = tshadow_q[ti] > temp_max_i[ti];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE:   if (sweep_edge) state_d = SNAP;
      SNAP: begin
        idx_d   = '0;
        state_d = SCAN_V;
      end
      SCAN_V: begin
        if (idx_q == IDX_W'(NV - 1)) begin
          idx_d   = '0;
          state_d = SCAN_T;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      SCAN_T: begin
        if (idx_q == IDX_W'(NT - 1)) state_d = DONE;
        else idx_d = idx_q + IDX_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NV; gi++) begin : g_vch
    logic hit;
    assign hit          = v_chk && (vi == VIDX_W'(gi));
    assign vdbc_d[gi]   = dbc_next(vdbc_q[gi], clear_i, hit, v_fail, DBC_LIM);
    assign vfault_d[gi] = (vfault_q[gi] & ~clear_i) | dbc_set(vdbc_q[gi], hit, v_fail, DBC_LIM);
  end

  for (genvar gi = 0; gi < NT; gi++) begin : g_tch
    logic hit;
    assign hit          = t_chk && (ti == TIDX_W'(gi));
    assign tdbc_d[gi]   = dbc_next(tdbc_q[gi], clear_i, hit, t_fail, DBC_LIM);
    assign tfault_d[gi] = (tfault_q[gi] & ~clear_i) | dbc_set(tdbc_q[gi], hit, t_fail, DBC_LIM);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      sw_q      <= 1'b0;
      vg_q      <= 1'b0;
      tg_q      <= 1'b0;
      vshadow_q <= '0;
      tshadow_q <= '0;
      vdbc_q    <= '0;
      tdbc_q    <= '0;
      vfault_q  <= '0;
      tfault_q  <= '0;
      overrun_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sw_q    <= voltage_good & temperature_good;
      vg_q    <= voltage_good;
      tg_q    <= temperature_good;
      if (state_q == SNAP) begin
        vshadow_q <= voltage_collection;
        tshadow_q <= temperature_collection;
      end
      vdbc_q    <= vdbc_d;
      tdbc_q    <= tdbc_d;
      vfault_q  <= vfault_d;
      tfault_q  <= tfault_d;
      overrun_q <= (overrun_q & ~clear_i) | (sweep_edge && (state_q != IDLE));
      fault_q   <= (|vfault_q) | (|tfault_q) | (|stale_w) | overrun_q;
    end
  end

  doc_hw_stale_wdog #(.P_STALE_CYCLES(P_STALE_CYCLES)) u_wdog_v (
    .clk(clk), .reset(reset), .kick_i(voltage_good & ~vg_q), .clear_i(clear_i), .stale_o(stale_w[0])
  );
  doc_hw_stale_wdog #(.P_STALE_CYCLES(P_STALE_CYCLES)) u_wdog_t (
    .clk(clk), .reset(reset), .kick_i(temperature_good & ~tg_q), .clear_i(clear_i), .stale_o(stale_w[1])
  );

  assign volt_fault_o  = vfault_q;
  assign temp_fault_o  = tfault_q;
  assign stale_fault_o = stale_w;
  assign overrun_o     = overrun_q;
  assign fault_o       = fault_q;
  assign scan_done_o   = (state_q == DONE);
endmodule

// File: tb/tb_doc_hw_sensor_limit_monitor.sv
// Scoreboard bench: each sweep pushes its expected completion cycle and fault vectors;
// a negedge monitor pops and compares whenever scan_done_o pulses.
module tb_doc_hw_sensor_limit_monitor;
  import doc_hw_pkg_hw::*;

  localparam int NV   = P_NO_CHANNELS;
  localparam int NT   = P_NO_TEMP_CHANNELS;
  localparam int P_DB = 3;
  localparam int P_ST = 200;

  logic clk = 1'b0;
  logic reset, voltage_good, temperature_good, clear_i;
  logic [NV-1:0][31:0] voltage_collection, volt_min_i, volt_max_i;
  logic [NT-1:0][7:0]  temperature_collection, temp_max_i;
  logic [NV-1:0] volt_fault_o;
  logic [NT-1:0] temp_fault_o;
  logic [1:0] stale_fault_o;
  logic overrun_o, fault_o, scan_done_o;

  doc_hw_sensor_limit_monitor #(.P_DEBOUNCE(P_DB), .P_STALE_CYCLES(P_ST)) dut (
    .clk(clk), .reset(reset), .voltage_good(voltage_good), .temperature_good(temperature_good),
    .voltage_collection(voltage_collection), .temperature_collection(temperature_collection),
    .volt_min_i(volt_min_i), .volt_max_i(volt_max_i), .temp_max_i(temp_max_i), .clear_i(clear_i),
    .volt_fault_o(volt_fault_o), .temp_fault_o(temp_fault_o), .stale_fault_o(stale_fault_o),
    .overrun_o(overrun_o), .fault_o(fault_o), .scan_done_o(scan_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [NV-1:0] vf;
    logic [NT-1:0] tf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vcnt[NV];
  int tcnt[NT];
  logic [NV-1:0] m_vf;
  logic [NT-1:0] m_tf;
  logic [31:0] vmin_l, vmax_l;
  logic [7:0]  tmax_l;
  int tkick_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (scan_done_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_scan_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        $display("scan_done cyc=%0d vf=%b tf=%b", cyc, volt_fault_o, temp_fault_o);
        chk("done_cyc", cyc, mon_e.cyc);
        chk("volt_fault", {28'd0, volt_fault_o}, {28'd0, mon_e.vf});
        chk("temp_fault", {30'd0, temp_fault_o}, {30'd0, mon_e.tf});
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < NV; i++) vcnt[i] = 0;
    for (int i = 0; i < NT; i++) tcnt[i] = 0;
    m_vf = '0;
    m_tf = '0;
  endtask

  task automatic model_sweep(input logic [NV-1:0][31:0] v, input logic [NT-1:0][7:0] t);
    for (int i = 0; i < NV; i++) begin
      if (v[i] < vmin_l || v[i] > vmax_l) begin
        if (vcnt[i] >= P_DB - 1) m_vf[i] = 1'b1;
        vcnt[i] = (vcnt[i] >= P_DB) ? P_DB : vcnt[i] + 1;
      end else vcnt[i] = 0;
    end
    for (int i = 0; i < NT; i++) begin
      if (t[i] > tmax_l) begin
        if (tcnt[i] >= P_DB - 1) m_tf[i] = 1'b1;
        tcnt[i] = (tcnt[i] >= P_DB) ? P_DB : tcnt[i] + 1;
      end else tcnt[i] = 0;
    end
  endtask

  // Raise both flags (edge cycle c), expect scan_done in cycle c+8.
  task automatic start_sweep(input logic [NV-1:0][31:0] v, input logic [NT-1:0][7:0] t,
                             input bit expect_done);
    exp_t e;
    @(negedge clk);
    voltage_collection = v;
    temperature_collection = t;
    voltage_good = 1'b1;
    temperature_good = 1'b1;
    tkick_cyc = cyc;
    if (expect_done) begin
      model_sweep(v, t);
      e.cyc = cyc + 8;
      e.vf = m_vf;
      e.tf = m_tf;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("scan_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic sweep(input logic [NV-1:0][31:0] v, input logic [NT-1:0][7:0] t);
    start_sweep(v, t, 1'b1);
    repeat (2) @(negedge clk);
    voltage_good = 1'b0;
    temperature_good = 1'b0;
    wait_drain();
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    model_clear();
  endtask

  // Keeps the voltage watchdog fed while temperature_good is held low.
  task automatic tick();
    @(negedge clk);
    voltage_good = (cyc % 50 == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [NV-1:0][31:0] vv;
    logic [NT-1:0][7:0]  tt;
    int first, k0, c;
    reset = 1'b0;
    voltage_good = 1'b1;
    temperature_good = 1'b1;
    clear_i = 1'b0;
    vmin_l = 32'd100;
    vmax_l = 32'd200;
    tmax_l = 8'd80;
    volt_min_i = {NV{vmin_l}};
    volt_max_i = {NV{vmax_l}};
    temp_max_i = {NT{tmax_l}};
    voltage_collection = {NV{32'd150}};
    temperature_collection = {NT{8'd50}};
    model_clear();

    // Reset with both goods high
    repeat (3) begin
      @(negedge clk);
      chk("reset_outs", {21'd0, volt_fault_o, temp_fault_o, stale_fault_o, overrun_o, fault_o, scan_done_o}, 0);
    end
    voltage_good = 1'b0;
    temperature_good = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_outs", {21'd0, volt_fault_o, temp_fault_o, stale_fault_o, overrun_o, fault_o, scan_done_o}, 0);

    // Passing sweep
    vv = {NV{32'd150}};
    tt = {NT{8'd50}};
    sweep(vv, tt);
    chk("pass_fault_o", fault_o, 0);

    // Debounce: ch2 over max on three consecutive sweeps
    vv[2] = 32'd250;
    repeat (3) sweep(vv, tt);
    chk("debounce_fault_o", fault_o, 1);
    pulse_clear();
    chk("clear_vfault", {28'd0, volt_fault_o}, 0);
    sweep(vv, tt);
    sweep(vv, tt);
    vv[2] = 32'd150;
    sweep(vv, tt);
    vv[2] = 32'd250;
    sweep(vv, tt);
    sweep(vv, tt);
    sweep(vv, tt);

    // Boundaries: inclusive limits pass, one past fails
    pulse_clear();
    vv[0] = 32'd100;
    vv[1] = 32'd200;
    vv[2] = 32'd99;
    vv[3] = 32'd201;
    tt[0] = 8'd80;
    tt[1] = 8'd81;
    repeat (3) sweep(vv, tt);
    chk("boundary_vf", {28'd0, volt_fault_o}, 32'hC);
    chk("boundary_tf", {30'd0, temp_fault_o}, 32'h2);

    // Stale temperature flag, clear, and clear coinciding with latch
    pulse_clear();
    vv = {NV{32'd150}};
    tt = {NT{8'd50}};
    sweep(vv, tt);
    first = -1;
    for (int i = 0; i < 300 && first < 0; i++) begin
      tick();
      if (stale_fault_o[1]) first = cyc;
    end
    chk("stale_latch_cyc", first, tkick_cyc + P_ST + 1);
    chk("stale_bits", {30'd0, stale_fault_o}, 32'h2);
    chk("fault_lag", fault_o, 0);
    tick();
    chk("fault_after_stale", fault_o, 1);
    tick();
    clear_i = 1'b1;
    k0 = cyc;
    tick();
    clear_i = 1'b0;
    chk("stale_cleared", {30'd0, stale_fault_o}, 0);
    while (cyc < k0 + P_ST - 2) tick();
    chk("stale_not_yet", {30'd0, stale_fault_o}, 0);
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("stale_set_wins", {30'd0, stale_fault_o}, 32'h2);
    voltage_good = 1'b0;
    pulse_clear();
    @(negedge clk);
    chk("all_clear_fault_o", fault_o, 0);

    // Overrun: second edge while in SCAN_V
    start_sweep(vv, tt, 1'b1);
    @(negedge clk);
    @(negedge clk);
    voltage_good = 1'b0;
    temperature_good = 1'b0;
    @(negedge clk);
    voltage_good = 1'b1;
    temperature_good = 1'b1;
    @(negedge clk);
    voltage_good = 1'b0;
    temperature_good = 1'b0;
    wait_drain();
    repeat (12) @(negedge clk);
    chk("overrun", overrun_o, 1);
    chk("overrun_fault_o", fault_o, 1);

    // Reset during SCAN_T aborts without a scan_done_o
    start_sweep(vv, tt, 1'b0);
    c = tkick_cyc;
    repeat (2) @(negedge clk);
    voltage_good = 1'b0;
    temperature_good = 1'b0;
    while (cyc < c + 6) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    chk("midscan_reset_outs", {21'd0, volt_fault_o, temp_fault_o, stale_fault_o, overrun_o, fault_o, scan_done_o}, 0);
    repeat (12) @(negedge clk);
    chk("midscan_overrun", overrun_o, 0);
    sweep(vv, tt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
